res_buffer_ctrl: RTL and testbench
==================================

// Module: res_buffer_ctrl
// PURPOSE
//  Sequencer/arbiter for the single-port result buffer (res_buffer1-style: one write port,
//  combinational read at wr_addr). Shares the buffer between NUM_REQ PE-result requesters
//  during FILL, then drains all DEPTH entries in address order over a valid/ready stream.
//  Sits between the PE array outputs and the NPU output/writeback path.
// PARAMETERS
//  BIT_DEPTH   8   result word width
//  ADDR_WIDTH  10  buffer address width
//  DEPTH       26  entries per fill/drain frame (2..2**ADDR_WIDTH)
//  NUM_REQ     4   number of requesters (>=1)
// PORTS
//  clk           in   1                  clock, all logic on posedge
//  rst           in   1                  synchronous, active-high reset
//  start         in   1                  begin a frame (sampled in IDLE only)
//  req_valid     in   NUM_REQ            requester i has a result word
//  req_data      in   NUM_REQ*BIT_DEPTH  word i at [i*BIT_DEPTH +: BIT_DEPTH]
//  req_ready     out  NUM_REQ            one-hot grant; word i accepted this cycle
//  buf_data_in   out  BIT_DEPTH          to buffer data_in
//  buf_wr_addr   out  ADDR_WIDTH         to buffer wr_addr (also read address)
//  buf_wr_en     out  1                  to buffer wr_en
//  buf_data_out  in   BIT_DEPTH          from buffer data_out (combinational read)
//  out_data      out  BIT_DEPTH          drained word
//  out_valid     out  1                  out_data valid
//  out_ready     in   1                  downstream accepts
//  busy          out  1                  state != IDLE
//  done          out  1                  one-cycle pulse after last drained word
// BEHAVIOUR
//  States: IDLE -> FILL -> DRAIN -> IDLE. Registers: state, wr_ptr, rd_ptr, prio.
//  Reset: state=IDLE, wr_ptr=0, rd_ptr=0, prio=0, done=0; all outputs 0 while in IDLE.
//  IDLE: start=1 -> FILL, wr_ptr=0. start ignored in FILL/DRAIN.
//  FILL: grant (combinational) = one-hot select among req_valid per arbitration rule;
//   req_ready=grant; buf_wr_en=|grant; buf_data_in=selected word; buf_wr_addr=wr_ptr.
//   Write commits on the clk edge; wr_ptr++ per accepted word. No req_valid -> no write,
//   ptr holds. Max one word per cycle; losing requesters hold data (valid-stays-high rule).
//   Accept at wr_ptr==DEPTH-1 -> DRAIN, rd_ptr=0; no req_ready in the first DRAIN cycle.
//  DRAIN: buf_wr_en=0, buf_wr_addr=rd_ptr, out_data=buf_data_out (0-cycle read latency),
//   out_valid=1. Transfer when out_valid&out_ready -> rd_ptr++. Transfer at
//   rd_ptr==DEPTH-1 -> IDLE with done=1 for exactly that next cycle (done registered).
//   out_ready low: hold rd_ptr/out_data stable. req_ready=0 throughout DRAIN.
//  Pointers never exceed DEPTH-1; no wrap within a frame; reset to 0 at frame start.
//  rst mid-FILL/DRAIN: next cycle IDLE, pointers 0, out_valid/buf_wr_en/req_ready 0;
//   buffer contents are not cleared (don't-care, overwritten next frame).
//  busy=1 in FILL and DRAIN, 0 in IDLE (including done cycle).
// CONFIGURATION
//  RES_CTRL_RR_EN defined: round-robin; search starts at index prio, wraps modulo NUM_REQ;
//   after a grant to i, prio <= (i+1)%NUM_REQ. prio resets to 0 and persists across frames.
//  RES_CTRL_RR_EN undefined: fixed priority, lowest index wins; prio register absent.
// TESTING
//  1 reset: rst=1 2 cycles -> busy=0, done=0, out_valid=0, req_ready=0, buf_wr_en=0.
//  2 single req: start, req_valid=4'b0001, data=addr+1 -> 26 writes addr 0..25 in 26
//    cycles, then DRAIN out_ready=1 -> out_data 1..26, done pulse 1 cycle, busy=0.
//  3 contention: req_valid=4'b1111 held all FILL -> RR_EN grants 0,1,2,3,0,...;
//    without RR_EN grant always 4'b0001; buffer matches granted data in order.
//  4 backpressure: DRAIN with out_ready toggling 1,0,0,1 -> out_data stable while low,
//    exactly 26 transfers, no skip/duplicate; done after 26th.
//  5 gaps: req_valid idle 3 cycles mid-FILL -> wr_ptr holds, buf_wr_en=0, no lost words.
//  6 rst at wr_ptr=10 and again mid-DRAIN -> IDLE next cycle; new start refills from addr 0.

Source files
------------

// File: rtl/res_buffer_ctrl.sv
// res_buffer_ctrl: shares a single-port result buffer among NUM_REQ producers (FILL), then drains it in order.
// Define RES_CTRL_RR_EN for round-robin arbitration; otherwise the lowest requester index always wins.
module res_buffer_ctrl #(
    parameter int BIT_DEPTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 26,
    parameter int NUM_REQ    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BIT_DEPTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [BIT_DEPTH-1:0]         buf_data_in,
    output logic [ADDR_WIDTH-1:0]        buf_wr_addr,
    output logic                         buf_wr_en,
    input  logic [BIT_DEPTH-1:0]         buf_data_out,
    output logic [BIT_DEPTH-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   wr_ptr_r;
    logic [ADDR_WIDTH-1:0]   rd_ptr_r;
    logic                    done_r;
    logic [NUM_REQ-1:0]      grant_s;
    logic                    found_s;
    logic                    hit_s;
    logic [BIT_DEPTH-1:0]    sel_data_s;
`ifdef RES_CTRL_RR_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    logic [IDX_W-1:0]        prio_r;
    logic [IDX_W-1:0]        grant_idx_s;
    int                      cand_s;
`endif

    // One-hot arbitration among valid requesters; only exposed while filling
    always_comb begin
        grant_s    = '0;
        found_s    = 1'b0;
        hit_s      = 1'b0;
        sel_data_s = '0;
`ifdef RES_CTRL_RR_EN
        grant_idx_s = '0;
        cand_s      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = ((int'(prio_r) + k) >= NUM_REQ) ? (int'(prio_r) + k - NUM_REQ) : (int'(prio_r) + k);
            hit_s  = !found_s && req_valid[IDX_W'(cand_s)];
            grant_s[IDX_W'(cand_s)] = grant_s[IDX_W'(cand_s)] | hit_s;
            grant_idx_s = hit_s ? IDX_W'(cand_s) : grant_idx_s;
            found_s     = found_s | hit_s;
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            hit_s      = !found_s && req_valid[k];
            grant_s[k] = hit_s;
            found_s    = found_s | hit_s;
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_data_s = sel_data_s | ({BIT_DEPTH{grant_s[k]}} & req_data[k*BIT_DEPTH +: BIT_DEPTH]);
        end
    end

    // Output decode: everything is forced to zero in IDLE
    always_comb begin
        req_ready   = '0;
        buf_wr_en   = 1'b0;
        buf_data_in = '0;
        buf_wr_addr = '0;
        out_data    = '0;
        out_valid   = 1'b0;
        case (state_r)
            ST_FILL: begin
                req_ready   = grant_s;
                buf_wr_en   = |grant_s;
                buf_data_in = sel_data_s;
                buf_wr_addr = wr_ptr_r;
            end
            ST_DRAIN: begin
                buf_wr_addr = rd_ptr_r;
                out_data    = buf_data_out;
                out_valid   = 1'b1;
            end
            default: begin
                req_ready = '0;
            end
        endcase
        busy = (state_r != ST_IDLE);
        done = done_r;
    end

    // Frame sequencer: pointers, state, done pulse and arbitration priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            done_r   <= 1'b0;
`ifdef RES_CTRL_RR_EN
            prio_r   <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r  <= ST_FILL;
                        wr_ptr_r <= '0;
                        rd_ptr_r <= '0;
                    end
                end
                ST_FILL: begin
                    if (|grant_s) begin
`ifdef RES_CTRL_RR_EN
                        prio_r <= (grant_idx_s == LAST_IDX) ? '0 : (grant_idx_s + IDX_W'(1));
`endif
                        if (wr_ptr_r == LAST_ADDR) begin
                            state_r  <= ST_DRAIN;
                            rd_ptr_r <= '0;
                        end else begin
                            wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // out_valid is always high here, so out_ready alone marks a transfer
                    if (out_ready) begin
                        if (rd_ptr_r == LAST_ADDR) begin
                            state_r  <= ST_IDLE;
                            rd_ptr_r <= '0;
                            wr_ptr_r <= '0;
                            done_r   <= 1'b1;
                        end else begin
                            rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_res_buffer_ctrl.sv
// Scoreboard bench for res_buffer_ctrl: stimulus queues expected writes/drained words, a monitor pops and compares.
module tb_res_buffer_ctrl;
    localparam int BW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 26;
    localparam int NR    = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        logic [NR-1:0] grant;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*BW-1:0] req_data = '0;
    logic [NR-1:0]    req_ready;
    logic [BW-1:0]    buf_data_in;
    logic [AW-1:0]    buf_wr_addr;
    logic             buf_wr_en;
    logic [BW-1:0]    buf_data_out;
    logic [BW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             done;

    logic [BW-1:0]    mem [0:(1<<AW)-1];
    logic [BW-1:0]    exp_mem [0:DEPTH-1];
    wr_t              wq[$];
    logic [BW-1:0]    dq[$];
    int               checks = 0;
    int               errors = 0;
    int               tb_prio = 0;

    res_buffer_ctrl #(.BIT_DEPTH(BW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst), .start(start), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .buf_data_in(buf_data_in), .buf_wr_addr(buf_wr_addr),
        .buf_wr_en(buf_wr_en), .buf_data_out(buf_data_out), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural single-port buffer with combinational read at the write address
    always @(posedge clk) begin
        if (buf_wr_en) mem[buf_wr_addr] <= buf_data_in;
    end
    assign buf_data_out = mem[buf_wr_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        wr_t           e;
        logic [BW-1:0] d;
        logic          held;
        logic [BW-1:0] held_data;
        held = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (buf_wr_en) begin
                    checks++;
                    if (wq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write", buf_wr_addr, buf_data_in);
                    end else begin
                        e = wq.pop_front();
                        if (buf_wr_addr !== e.addr || buf_data_in !== e.data || req_ready !== e.grant) begin
                            errors++;
                            $display("FAIL fill_write: got addr=%0d data=%02h grant=%b, required addr=%0d data=%02h grant=%b",
                                     buf_wr_addr, buf_data_in, req_ready, e.addr, e.data, e.grant);
                        end
                    end
                end
                if (out_valid) begin
                    checks++;
                    if (req_ready !== '0 || buf_wr_en !== 1'b0) begin
                        errors++;
                        $display("FAIL drain_no_grant: got req_ready=%b wr_en=%b, required 0", req_ready, buf_wr_en);
                    end
                    if (held) begin
                        checks++;
                        if (out_data !== held_data) begin
                            errors++;
                            $display("FAIL drain_stable: got %02h required %02h", out_data, held_data);
                        end
                    end
                    if (out_ready) begin
                        checks++;
                        if (dq.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_xfer: got %02h, required no transfer", out_data);
                        end else begin
                            d = dq.pop_front();
                            if (out_data !== d) begin
                                errors++;
                                $display("FAIL drain_data: got %02h required %02h", out_data, d);
                            end
                        end
                    end
                end
                held = out_valid && !out_ready;
                held_data = out_data;
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_fill(input logic [NR-1:0] vmask, input int n_stop, input int gap_at,
                           input int gap_len, input int base);
        int   acc[NR];
        int   exp_cnt[NR];
        int   accepted;
        int   cyc;
        int   gap_left;
        int   g;
        int   c;
        logic gap_now;
        wr_t  e;
        for (int i = 0; i < NR; i++) begin
            acc[i] = 0;
            exp_cnt[i] = 0;
        end
        // Reference arbitration model producing the expected write sequence
        for (int k = 0; k < n_stop; k++) begin
            g = -1;
`ifdef RES_CTRL_RR_EN
            for (int j = 0; j < NR; j++) begin
                c = (tb_prio + j) % NR;
                if (g < 0 && vmask[c]) g = c;
            end
`else
            for (int j = NR - 1; j >= 0; j--) begin
                if (vmask[j]) g = j;
            end
`endif
            e.addr  = AW'(k);
            e.data  = BW'(base + 16 * g + exp_cnt[g]);
            e.grant = NR'(1 << g);
            wq.push_back(e);
            exp_mem[k] = e.data;
            exp_cnt[g]++;
            tb_prio = (g + 1) % NR;
        end
        accepted = 0;
        cyc = 0;
        gap_left = gap_len;
        while (accepted < n_stop && cyc < 200) begin
            if (accepted == gap_at && gap_left > 0) begin
                req_valid = '0;
                gap_left--;
                gap_now = 1'b1;
            end else begin
                req_valid = vmask;
                gap_now = 1'b0;
            end
            for (int i = 0; i < NR; i++) req_data[i*BW +: BW] = BW'(base + 16 * i + acc[i]);
            @(negedge clk);
            if (gap_now) chk("gap_no_write", 32'(buf_wr_en), 32'd0);
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) begin
                    acc[i]++;
                    accepted++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = '0;
        chk("fill_cycles", 32'(cyc), 32'(n_stop + gap_len));
    endtask

    task automatic do_drain(input int n, input logic bp, input logic full);
        logic [3:0] pat;
        int         xf;
        int         cyc;
        pat = 4'b1001;
        for (int k = 0; k < n; k++) dq.push_back(exp_mem[k]);
        xf = 0;
        cyc = 0;
        while (xf < n && cyc < 400) begin
            out_ready = bp ? pat[cyc % 4] : 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) xf++;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_xfers", 32'(xf), 32'(n));
        if (full) begin
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'd1);
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("valid_at_done", 32'(out_valid), 32'd0);
            chk("scoreboard_empty", 32'(dq.size() + wq.size()), 32'd0);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_now();
        rst = 1'b1;
        tb_prio = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_wr_en", 32'(buf_wr_en), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        // Power-on reset held two cycles
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("por_busy", 32'(busy), 32'd0);
        chk("por_done", 32'(done), 32'd0);
        chk("por_valid", 32'(out_valid), 32'd0);
        chk("por_req_ready", 32'(req_ready), 32'd0);
        chk("por_wr_en", 32'(buf_wr_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tb_prio = 0;

        do_start(); do_fill(4'b0001, DEPTH, -1, 0, 1);     do_drain(DEPTH, 1'b0, 1'b1);
        do_start(); do_fill(4'b1111, DEPTH, -1, 0, 0);     do_drain(DEPTH, 1'b1, 1'b1);
        do_start(); do_fill(4'b0101, DEPTH, 10, 3, 8'h80); do_drain(DEPTH, 1'b0, 1'b1);

        // Reset mid-FILL at wr_ptr=10, then mid-DRAIN after 5 words
        do_start(); do_fill(4'b1111, 10, -1, 0, 8'h60);
        reset_now();
        do_start(); do_fill(4'b0001, DEPTH, -1, 0, 8'h41); do_drain(5, 1'b0, 1'b0);
        reset_now();
        chk("rst_scoreboard_empty", 32'(dq.size() + wq.size()), 32'd0);
        do_start(); do_fill(4'b0011, DEPTH, -1, 0, 8'h20); do_drain(DEPTH, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
